// File: rtl/div_unit.sv
// Multicycle signed divider: restoring division over operand magnitudes,
// one quotient bit per clock, quotient to LO and remainder to HI.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dloadab,
    input  logic             div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             divzero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FIX   = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dmag;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_done;
    logic             r_divzero;
    logic             r_busy;

    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;

    // Magnitudes wrap naturally: the most negative value maps to itself as unsigned.
    assign w_a_neg  = r_a[WIDTH-1];
    assign w_b_neg  = r_b[WIDTH-1];
    assign w_b_zero = (r_b == '0);
    assign w_a_mag  = w_a_neg ? -r_a : r_a;
    assign w_b_mag  = w_b_neg ? -r_b : r_b;

    // One restoring step: shift in the next dividend bit, try subtracting the divisor.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_dmag};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (div) w_state_nxt = S_SETUP;
            S_SETUP: w_state_nxt = w_b_zero ? S_IDLE : S_RUN;
            S_RUN:   if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dmag    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_busy    <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (dloadab) begin
                        r_a <= a_in;
                        r_b <= b_in;
                    end
                end
                S_SETUP: begin
                    if (w_b_zero) begin
                        r_divzero <= 1'b1;
                    end else begin
                        r_rem   <= '0;
                        r_quo   <= w_a_mag;
                        r_dmag  <= w_b_mag;
                        r_cnt   <= CW'(WIDTH);
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                    end
                end
                S_RUN: begin
                    r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_rem <= w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_lo   <= r_neg_q ? -r_quo : r_quo;
                    r_hi   <= r_neg_r ? -r_rem : r_rem;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hi_out  = r_hi;
    assign lo_out  = r_lo;
    assign busy    = r_busy;
    assign done    = r_done;
    assign divzero = r_divzero;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected HI/LO queued at issue, checked on done.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        dloadab;
    logic        div;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        divzero;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] sb_q[$];

    div_unit #(.WIDTH(32)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .dloadab (dloadab),
        .div     (div),
        .a_in    (a_in),
        .b_in    (b_in),
        .hi_out  (hi_out),
        .lo_out  (lo_out),
        .busy    (busy),
        .done    (done),
        .divzero (divzero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit signed arithmetic sidesteps the 32-bit overflow case.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit load);
        dloadab = load;
        div     = 1'b1;
        a_in    = a;
        b_in    = b;
        @(posedge clk);
        @(negedge clk);
        dloadab = 1'b0;
        div     = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit load,
                         input logic [63:0] exp);
        sb_q.push_back(exp);
        start_op(a, b, load);
    endtask

    task automatic wait_done(input string tag);
        int          lat  = 0;
        bit          seen = 1'b0;
        logic [63:0] e;
        while (!seen && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) chk({tag, "_busy_run"}, 32'(busy), 32'd1);
            if (done) begin
                seen = 1'b1;
                chk({tag, "_latency"}, 32'(lat), 32'd34);
                chk({tag, "_busy_done"}, 32'(busy), 32'd0);
                chk({tag, "_dz_excl"}, 32'(divzero), 32'd0);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk({tag, "_lo"}, lo_out, e[31:0]);
                    chk({tag, "_hi"}, hi_out, e[63:32]);
                end else begin
                    chk({tag, "_sb_empty"}, 32'd0, 32'd1);
                end
            end
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          n_done;
        int          dz_cnt;
        int          done_lat;

        reset   = 1'b1;
        dloadab = 1'b0;
        div     = 1'b0;
        a_in    = '0;
        b_in    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dz", 32'(divzero), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Sign combinations, issued back to back in each done cycle.
        issue(32'd7, 32'd2, 1'b1, {32'h0000_0001, 32'h0000_0003});
        wait_done("pp");
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_done("np");
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD});
        wait_done("pn");
        issue(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, {32'hFFFF_FFFF, 32'h0000_0003});
        wait_done("nn");
        issue(32'd7, 32'd2, 1'b1, {32'h0000_0001, 32'h0000_0003});
        wait_done("preload");

        // Divide by zero: single pulse after edge 1, HI/LO untouched.
        start_op(32'd5, 32'd0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("dz_pulse", 32'(divzero), 32'd1);
        chk("dz_busy", 32'(busy), 32'd0);
        chk("dz_done", 32'(done), 32'd0);
        chk("dz_hi", hi_out, 32'd1);
        chk("dz_lo", lo_out, 32'd3);
        n_done = 0;
        dz_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) n_done++;
            if (divzero) dz_cnt++;
        end
        chk("dz_width", 32'(dz_cnt), 32'd0);
        chk("dz_no_done", 32'(n_done), 32'd0);
        chk("dz_hi_hold", hi_out, 32'd1);

        // Overflow plus a mid-run request that must be ignored.
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000});
        n_done   = 0;
        done_lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 5) begin
                dloadab = 1'b1;
                div     = 1'b1;
                a_in    = 32'd1;
                b_in    = 32'd1;
            end else if (c == 6) begin
                dloadab = 1'b0;
                div     = 1'b0;
            end
            if (done) begin
                n_done++;
                done_lat = c;
                if (sb_q.size() > 0) begin
                    chk("ovf_lo", lo_out, sb_q[0][31:0]);
                    chk("ovf_hi", hi_out, sb_q[0][63:32]);
                    void'(sb_q.pop_front());
                end
            end
        end
        chk("ovf_ndone", 32'(n_done), 32'd1);
        chk("ovf_lat", 32'(done_lat), 32'd34);
        // Operand registers must still hold the overflow pair.
        issue(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, {32'h0, 32'h8000_0000});
        wait_done("reuse");

        // Corner operands and random ones against the reference.
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, model(32'h8000_0000, 32'h8000_0000));
        wait_done("minmin");
        issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, model(32'h7FFF_FFFF, 32'h8000_0000));
        wait_done("maxmin");
        issue(32'h8000_0000, 32'd1, 1'b1, model(32'h8000_0000, 32'd1));
        wait_done("min_one");
        issue(32'd0, 32'd5, 1'b1, {32'd0, 32'd0});
        wait_done("zero_num");
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            if (rb == 32'd0) rb = 32'd3;
            issue(ra, rb, 1'b1, model(ra, rb));
            wait_done("rand");
        end

        // Reset mid-operation clears everything, including the operand registers.
        issue(32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        chk("mrst_hi", hi_out, 32'd0);
        chk("mrst_lo", lo_out, 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_dz", 32'(divzero), 32'd0);
        start_op(32'd100, 32'd7, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("mrst_opclr", 32'(divzero), 32'd1);
        @(negedge clk);
        issue(32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
        wait_done("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
